two_to_four_decoder: RTL and testbench

TWO_TO_FOUR_DECODER -- requirements
Module: two_to_four_decoder

---
 rtl/two_to_four_decoder.sv | 92 +++++++++
 tb/tb_two_to_four_decoder.sv | 114 +++++++++++
 2 files changed

// File: rtl/two_to_four_decoder.sv
// Two-entry buffered 2-to-4 decoder with valid/ready handshakes.
// Per-output saturating hit counters, readable through a select mux.
module two_to_four_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e0,
  input  logic             e1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [1:0]       mem_q [2];
  logic             wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q [4];

  logic       push, pop;
  logic [1:0] head;
  logic [1:0] hit_idx;

  assign in_ready  = (occ_q != FULL) & ~rst;
  assign out_valid = (occ_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_q];

  assign a = out_valid & (head == 2'b00);
  assign b = out_valid & (head == 2'b10);
  assign c = out_valid & (head == 2'b01);
  assign d = out_valid & (head == 2'b11);

  // Counter index follows cnt_sel order a,b,c,d: e0 is the msb.
  assign hit_idx = {head[0], head[1]};

  assign cnt = cnt_q[cnt_sel];

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = (occ_q == EMPTY) ? ONE : FULL;
      2'b01:   occ_d = (occ_q == ONE) ? EMPTY : ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {e1, e0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= EMPTY;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clr) begin
        cnt_q[i] <= '0;
      end else if (pop && hit_idx == 2'(i)
                   && cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_two_to_four_decoder.sv
// Directed bench for two_to_four_decoder: vector table
// plus saturation and clear sequences.
module tb_two_to_four_decoder;

  logic       clk = 1'b0;
  logic       rst, e0, e1, in_valid, out_ready, clr;
  logic [1:0] cnt_sel;
  logic       in_ready, a, b, c, d, out_valid;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two_to_four_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .e0(e0), .e1(e1),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .clr(clr), .cnt_sel(cnt_sel), .cnt(cnt)
  );

  typedef struct {
    logic       rst, iv, e1, e0, ordy, clr;
    logic [1:0] sel;
    logic       x_ir, x_ov;
    logic [3:0] x_abcd;
    logic [7:0] x_cnt;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         rst iv e1 e0 ordy clr sel  ir ov abcd     cnt
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
    vt[1]  = '{0, 1, 1, 1, 1, 0, 3,  1, 1, 4'b0001, 0};
    vt[2]  = '{0, 0, 0, 0, 1, 0, 3,  1, 0, 4'b0000, 1};
    vt[3]  = '{0, 1, 0, 0, 0, 0, 0,  1, 1, 4'b1000, 0};
    vt[4]  = '{0, 1, 1, 0, 0, 0, 0,  0, 1, 4'b1000, 0};
    vt[5]  = '{0, 1, 0, 1, 0, 0, 0,  0, 1, 4'b1000, 0};
    vt[6]  = '{0, 0, 0, 0, 1, 0, 0,  1, 1, 4'b0100, 1};
    vt[7]  = '{0, 1, 0, 1, 1, 0, 1,  1, 1, 4'b0010, 1};
    vt[8]  = '{0, 0, 0, 0, 1, 0, 2,  1, 0, 4'b0000, 1};
    vt[9]  = '{0, 1, 1, 1, 0, 0, 3,  1, 1, 4'b0001, 1};
    vt[10] = '{0, 1, 0, 0, 0, 0, 3,  0, 1, 4'b0001, 1};
    vt[11] = '{1, 1, 1, 0, 1, 0, 3,  0, 0, 4'b0000, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 4'b0000, 0};
    vt[13] = '{0, 1, 1, 0, 1, 0, 1,  1, 1, 4'b0100, 0};
    vt[14] = '{0, 0, 0, 0, 1, 1, 1,  1, 0, 4'b0000, 0};

    rst = 1'b1; in_valid = 1'b0; e0 = 1'b0; e1 = 1'b0;
    out_ready = 1'b0; clr = 1'b0; cnt_sel = 2'd0;
    step();
    step();

    for (int i = 0; i < 15; i++) begin
      rst       = vt[i].rst;
      in_valid  = vt[i].iv;
      e1        = vt[i].e1;
      e0        = vt[i].e0;
      out_ready = vt[i].ordy;
      clr       = vt[i].clr;
      cnt_sel   = vt[i].sel;
      step();
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].x_ir));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].x_ov));
      chk($sformatf("v%0d abcd", i), 32'({a, b, c, d}), 32'(vt[i].x_abcd));
      chk($sformatf("v%0d cnt", i), 32'(cnt), 32'(vt[i].x_cnt));
    end

    // Stream code 00 with out_ready high: one pop per cycle after the first.
    rst = 1'b0; in_valid = 1'b1; e1 = 1'b0; e0 = 1'b0;
    out_ready = 1'b1; clr = 1'b0; cnt_sel = 2'd0;
    for (int i = 0; i < 10; i++) step();
    chk("stream cnt9", 32'(cnt), 32'd9);
    for (int i = 0; i < 300; i++) step();
    chk("sat cnt_a", 32'(cnt), 32'd255);
    chk("sat a", 32'(a), 32'd1);

    clr = 1'b1;
    step();
    chk("clr cnt_a", 32'(cnt), 32'd0);
    chk("clr out_valid", 32'(out_valid), 32'd1);
    chk("clr a", 32'(a), 32'd1);

    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk($sformatf("post clr cnt%0d", s), 32'(cnt), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
